// File: rtl/div_nrest_arbiter_pkg.sv
// Shared definitions for the divider arbiter: FSM states, divide-by-zero
// quotient constant and the one-hot to index helper.
package div_nrest_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_e;

    // Widest supported operand / requester count; users truncate with N'(...)
    localparam int unsigned MAX_W   = 64;
    localparam int unsigned MAX_REQ = 32;

    localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/div_nrest_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i,
// wrapping at NREQ.
module div_nrest_arbiter_rr_pick
    import div_nrest_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IW-1:0]   win_idx_o,
    output logic            any_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        win_o = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_i[IW'((32'(rr_ptr_i) + k) % NREQ)]) begin
                win_o[IW'((32'(rr_ptr_i) + k) % NREQ)] = 1'b1;
                found = 1'b1;
            end
        end
    end

    assign win_idx_o = IW'(onehot_to_idx(MAX_REQ'(win_o)));
    assign any_o     = |req_i;

endmodule

// File: rtl/div_nrest_arbiter.sv
// Shares one non-restoring divider among NREQ requesters with round-robin
// arbitration, divide-by-zero short-circuit and a hung-divider timeout.
module div_nrest_arbiter
    import div_nrest_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned N       = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] dividend,
    input  logic [NREQ*N-1:0] divisor,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      quotient,
    output logic [N-1:0]      remainder,
    output logic              err,
    output logic              busy,
    output logic              div_start,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    input  logic              div_done,
    input  logic [N-1:0]      div_quotient,
    input  logic [N-1:0]      div_remainder
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] rsp_q, rsp_d;
    logic [N-1:0]    quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            start_q, start_d;
    logic [N-1:0]    opa_q, opa_d;
    logic [N-1:0]    opb_q, opb_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

    logic [N-1:0]    dvd_arr [NREQ];
    logic [N-1:0]    dvs_arr [NREQ];
    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx;
    logic            any;

    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign dvd_arr[g] = dividend[g*N +: N];
        assign dvs_arr[g] = divisor[g*N +: N];
    end

    div_nrest_arbiter_rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req_i     (req),
        .rr_ptr_i  (rr_ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (any)
    );

    // Saturating wait counter so a stuck divider never wraps back below TIMEOUT
    assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rsp_d    = '0;
        quot_d   = quot_q;
        rem_d    = rem_q;
        err_d    = err_q;
        start_d  = 1'b0;
        opa_d    = opa_q;
        opb_d    = opb_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (any) begin
                    state_d = S_ARB;
                    gnt_d   = win;
                    owner_d = win_idx;
                    opa_d   = dvd_arr[win_idx];
                    opb_d   = dvs_arr[win_idx];
                end
            end
            S_ARB: begin
                if (opb_q == '0) begin
                    state_d = S_RESP;
                    quot_d  = N'(DIV0_QUOT);
                    rem_d   = opa_q;
                    err_d   = 1'b1;
                    rsp_d   = gnt_q;
                end else begin
                    state_d = S_LAUNCH;
                    start_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A done arriving on the timeout cycle still delivers its result
                if (div_done) begin
                    state_d = S_RESP;
                    quot_d  = div_quotient;
                    rem_d   = div_remainder;
                    err_d   = 1'b0;
                    rsp_d   = gnt_q;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    state_d = S_RESP;
                    quot_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    rsp_d   = gnt_q;
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                gnt_d    = '0;
                rr_ptr_d = (32'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            rsp_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rsp_q    <= rsp_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt          = gnt_q;
    assign rsp_valid    = rsp_q;
    assign quotient     = quot_q;
    assign remainder    = rem_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign div_start    = start_q;
    assign div_dividend = opa_q;
    assign div_divisor  = opb_q;

endmodule

// File: tb/tb_div_nrest_arbiter.sv
// Bench for div_nrest_arbiter: behavioural divider, operation-level reference
// model compared every cycle, plus directed scenarios with literal results.
module tb_div_nrest_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 8;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] dividend, divisor;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic [N-1:0]      quotient, remainder;
    logic              err, busy, div_start;
    logic [N-1:0]      div_dividend, div_divisor;
    logic              div_done;
    logic [N-1:0]      div_quotient, div_remainder;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    div_nrest_arbiter #(.NREQ(NREQ), .N(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .dividend(dividend), .divisor(divisor),
        .gnt(gnt), .rsp_valid(rsp_valid), .quotient(quotient), .remainder(remainder),
        .err(err), .busy(busy), .div_start(div_start), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_done(div_done), .div_quotient(div_quotient),
        .div_remainder(div_remainder)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: result 'dly' cycles after start, or never when hang=1
    int dly = 1;
    bit hang = 0;
    int dcnt;
    logic [N-1:0] da, db;
    initial begin
        div_done = 1'b0; div_quotient = 8'hA5; div_remainder = 8'h5A; dcnt = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            div_done = 1'b0; div_quotient = 8'hA5; div_remainder = 8'h5A;
            if (!rst_n) begin
                dcnt = 0;
            end else if (div_start) begin
                da = div_dividend; db = div_divisor;
                dcnt = hang ? 0 : dly;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) begin
                    div_done = 1'b1; div_quotient = da / db; div_remainder = da % db;
                end
            end
        end
    end

    // Reference model: one operation tracked by cycle offset t since its grant
    bit m_busy;
    int m_owner, m_t, m_resp_t, m_rr, tp, pick;
    logic [N-1:0] m_a, m_b, m_q, m_r;
    logic m_e;
    initial begin
        m_busy = 0; m_owner = 0; m_t = 0; m_resp_t = -1; m_rr = 0;
        m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_e = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 0; m_owner = 0; m_t = 0; m_resp_t = -1; m_rr = 0;
                m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_e = 0;
            end else if (!m_busy) begin
                pick = -1;
                for (int k = 0; k < NREQ; k++)
                    if (pick < 0 && req[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
                if (pick >= 0) begin
                    m_busy = 1; m_owner = pick; m_t = 1; m_resp_t = -1;
                    m_a = dividend[pick*N +: N]; m_b = divisor[pick*N +: N];
                end
            end else begin
                tp = m_t; m_t = m_t + 1;
                if (tp == m_resp_t) begin
                    m_busy = 0; m_rr = (m_owner + 1) % NREQ;
                end else if (tp == 1 && m_b == 0) begin
                    m_resp_t = m_t; m_q = 8'hFF; m_r = m_a; m_e = 1;
                end else if (tp >= 3 && m_resp_t < 0) begin
                    if (div_done) begin
                        m_resp_t = m_t; m_q = m_a / m_b; m_r = m_a % m_b; m_e = 0;
                    end else if (tp - 2 == TO) begin
                        m_resp_t = m_t; m_q = 0; m_r = 0; m_e = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    logic [NREQ-1:0] e_gnt, e_rsp;
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            e_gnt = '0;
            if (m_busy) e_gnt[m_owner] = 1'b1;
            e_rsp = (m_busy && m_t == m_resp_t) ? e_gnt : '0;
            chk("gnt", 32'(gnt), 32'(e_gnt));
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("div_start", 32'(div_start), 32'(m_busy && m_t == 2 && m_b != 0));
            chk("quotient", 32'(quotient), 32'(m_q));
            chk("remainder", 32'(remainder), 32'(m_r));
            chk("err", 32'(err), 32'(m_e));
            chk("div_dividend", 32'(div_dividend), 32'(m_a));
            chk("div_divisor", 32'(div_divisor), 32'(m_b));
        end
    end

    task automatic set_op(input int i, input int a, input int b);
        dividend[i*N +: N] = N'(a);
        divisor[i*N +: N]  = N'(b);
    endtask

    // Count negedges until rsp_valid; records grant seen on the first cycle
    task automatic wait_rsp(input int budget, output int n, output logic [NREQ-1:0] rv,
                            output int starts, output logic [NREQ-1:0] g1);
        n = 0; starts = 0; rv = '0; g1 = '0;
        while (n < budget && rv == '0) begin
            @(negedge clk);
            n++;
            if (n == 1) g1 = gnt;
            if (div_start) starts++;
            if (rsp_valid != '0) rv = rsp_valid;
        end
        if (rv == '0) begin
            n_chk++; n_err++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
        end
    endtask

    int n, st;
    logic [NREQ-1:0] rv, g1;
    int eq[4] = '{66, 10, 9, 1};
    int er[4] = '{2, 0, 5, 0};

    initial begin
        rst_n = 1'b0; req = '0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single request 100/7 from requester 1
        set_op(1, 100, 7); dly = 1; req = 4'b0010;
        wait_rsp(20, n, rv, st, g1);
        chk("t1_gnt", 32'(g1), 32'h2);
        chk("t1_latency", 32'(n), 32'd4);
        chk("t1_rsp", 32'(rv), 32'h2);
        chk("t1_quot", 32'(quotient), 32'd14);
        chk("t1_rem", 32'(remainder), 32'd2);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_starts", 32'(st), 32'd1);
        req = '0;
        repeat (2) @(negedge clk);

        // Divide by zero from requester 2
        set_op(2, 9, 0); req = 4'b0100;
        wait_rsp(20, n, rv, st, g1);
        chk("t3_latency", 32'(n), 32'd2);
        chk("t3_rsp", 32'(rv), 32'h4);
        chk("t3_quot", 32'(quotient), 32'd255);
        chk("t3_rem", 32'(remainder), 32'd9);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_starts", 32'(st), 32'd0);
        req = '0;
        repeat (2) @(negedge clk);

        // Hung divider on requester 3: timeout after TO cycles in WAIT
        set_op(3, 50, 5); hang = 1; req = 4'b1000;
        wait_rsp(200, n, rv, st, g1);
        chk("t4_latency", 32'(n), 32'(3 + TO));
        chk("t4_rsp", 32'(rv), 32'h8);
        chk("t4_quot", 32'(quotient), 32'd0);
        chk("t4_rem", 32'(remainder), 32'd0);
        chk("t4_err", 32'(err), 32'd1);
        req = '0; hang = 0;
        @(negedge clk);
        chk("t4_idle", 32'(busy), 32'd0);
        @(negedge clk);

        // All four requesting: round-robin order 0,1,2,3 from rr_ptr=0
        set_op(0, 200, 3); set_op(1, 50, 5); set_op(2, 77, 8); set_op(3, 13, 13);
        dly = 2; req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(30, n, rv, st, g1);
            chk("t2_order", 32'(rv), 32'(1 << k));
            chk("t2_quot", 32'(quotient), 32'(eq[k]));
            chk("t2_rem", 32'(remainder), 32'(er[k]));
            chk("t2_starts", 32'(st), 32'd1);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Requester 3 drops req mid-op while 1 and 2 become pending
        set_op(3, 90, 9); dly = 6; req = 4'b1000;
        repeat (4) @(negedge clk);
        req = 4'b0110;
        wait_rsp(30, n, rv, st, g1);
        chk("t6_rsp", 32'(rv), 32'h8);
        chk("t6_quot", 32'(quotient), 32'd10);
        chk("t6_rem", 32'(remainder), 32'd0);
        wait_rsp(30, n, rv, st, g1);
        chk("t6_next", 32'(rv), 32'h2);
        chk("t6_next_quot", 32'(quotient), 32'd10);
        req = '0;
        repeat (2) @(negedge clk);

        // Reset during WAIT, then a fresh 255/16 operation
        set_op(1, 200, 10); hang = 1; req = 4'b0010;
        repeat (5) @(negedge clk);
        chk("t5_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0; req = '0;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_gnt", 32'(gnt), 32'd0);
        chk("t5_start", 32'(div_start), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1; hang = 0; dly = 3;
        set_op(0, 255, 16);
        @(negedge clk);
        req = 4'b0001;
        wait_rsp(30, n, rv, st, g1);
        chk("t5_latency", 32'(n), 32'd6);
        chk("t5_rsp", 32'(rv), 32'h1);
        chk("t5_quot", 32'(quotient), 32'd15);
        chk("t5_rem", 32'(remainder), 32'd15);
        chk("t5_err", 32'(err), 32'd0);
        req = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
